// File: rtl/updown_stepper.sv
// updown_stepper: walks one lit LED one position per rising edge of sclk.
// Define UPDOWN_STEPPER_BOUNCE_EN for ping-pong travel instead of wrap-around.
module updown_stepper #(
  parameter int LEDS = 8,
  parameter int PW   = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sclk,
  input  logic            dir,
  output logic [LEDS-1:0] leds,
  output logic [PW-1:0]   pos,
  output logic            step,
  output logic            heading
);

  localparam logic [PW-1:0] LAST = PW'(LEDS - 1);
  localparam logic [PW-1:0] ONE  = PW'(1);

  logic            sclk_q;
  logic            step_edge;
  logic [PW-1:0]   pos_q, pos_d;
  logic [LEDS-1:0] leds_q, leds_d;
  logic            step_q;

`ifdef UPDOWN_STEPPER_BOUNCE_EN
  logic flip_q, flip_d;

  assign heading = dir ^ flip_q;
`else
  assign heading = dir;
`endif

  always_comb begin
    step_edge = sclk & ~sclk_q;
    pos_d     = pos_q;
`ifdef UPDOWN_STEPPER_BOUNCE_EN
    flip_d    = flip_q;
`endif
    if (step_edge) begin
`ifdef UPDOWN_STEPPER_BOUNCE_EN
      // at an end the walk reflects instead of wrapping
      if (heading && pos_q == LAST) begin
        flip_d = ~flip_q;
        pos_d  = LAST - ONE;
      end else if (!heading && pos_q == '0) begin
        flip_d = ~flip_q;
        pos_d  = ONE;
      end else if (heading) begin
        pos_d = pos_q + ONE;
      end else begin
        pos_d = pos_q - ONE;
      end
`else
      // explicit compare: LEDS need not be a power of two
      if (heading) begin
        pos_d = (pos_q == LAST) ? '0 : pos_q + ONE;
      end else begin
        pos_d = (pos_q == '0) ? LAST : pos_q - ONE;
      end
`endif
    end
    leds_d = LEDS'(1) << pos_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q <= 1'b1;
      pos_q  <= '0;
      leds_q <= LEDS'(1);
      step_q <= 1'b0;
`ifdef UPDOWN_STEPPER_BOUNCE_EN
      flip_q <= 1'b0;
`endif
    end else begin
      sclk_q <= sclk;
      pos_q  <= pos_d;
      leds_q <= leds_d;
      step_q <= step_edge;
`ifdef UPDOWN_STEPPER_BOUNCE_EN
      flip_q <= flip_d;
`endif
    end
  end

  assign pos  = pos_q;
  assign leds = leds_q;
  assign step = step_q;

endmodule

// File: tb/tb_updown_stepper.sv
// tb_updown_stepper: directed table, hand sequences and random run
// against a position-arithmetic reference model (LEDS=8).
module tb_updown_stepper;

  localparam int LEDS = 8;
  localparam int PW   = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            sclk = 1'b1;
  logic            dir = 1'b1;
  logic [LEDS-1:0] leds;
  logic [PW-1:0]   pos;
  logic            step;
  logic            heading;

  int errors = 0;
  int checks = 0;

  int m_pos  = 0;
  int m_sq   = 1;
  int m_flip = 0;
  int m_step = 0;

  updown_stepper #(.LEDS(LEDS), .PW(PW)) dut (
    .clk    (clk),
    .rst    (rst),
    .sclk   (sclk),
    .dir    (dir),
    .leds   (leds),
    .pos    (pos),
    .step   (step),
    .heading(heading)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic r;
    logic s;
    logic d;
    int   ep;
    logic es;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: position as plain integer on a line of LEDS slots
  task automatic model_edge(input logic r, input logic s, input logic d);
    int h;
    int np;
    if (r) begin
      m_pos = 0; m_sq = 1; m_flip = 0; m_step = 0;
    end else begin
      m_step = (s && m_sq == 0) ? 1 : 0;
      m_sq = s;
      if (m_step == 1) begin
        h = d ^ m_flip;
        np = m_pos + (h ? 1 : -1);
`ifdef UPDOWN_STEPPER_BOUNCE_EN
        if (np > LEDS - 1) begin
          np = LEDS - 2; m_flip ^= 1;
        end else if (np < 0) begin
          np = 1; m_flip ^= 1;
        end
`else
        np = (np + LEDS) % LEDS;
`endif
        m_pos = np;
      end
    end
  endtask

  task automatic tick(input logic r, input logic s, input logic d);
    rst = r; sclk = s; dir = d;
    @(posedge clk);
    #1;
    model_edge(r, s, d);
    chk("pos", pos, m_pos);
    chk("leds", leds, longint'(1) << m_pos);
    chk("step", step, m_step);
    chk("heading", heading, d ^ m_flip[0]);
  endtask

  task automatic do_reset();
    tick(1, 1, 1);
    tick(1, 1, 1);
    tick(1, 1, 1);
  endtask

  task automatic pulse(input logic d);
    tick(0, 0, d);
    tick(0, 1, d);
  endtask

  int exp_up[10];
  int nsteps;

  initial begin
    tbl[0]  = '{1, 1, 1, 0, 0};
    tbl[1]  = '{1, 1, 1, 0, 0};
    tbl[2]  = '{1, 1, 1, 0, 0};
    tbl[3]  = '{0, 1, 1, 0, 0};
    tbl[4]  = '{0, 1, 1, 0, 0};
    tbl[5]  = '{0, 0, 1, 0, 0};
    tbl[6]  = '{0, 1, 1, 1, 1};
    tbl[7]  = '{0, 0, 1, 1, 0};
    tbl[8]  = '{0, 1, 1, 2, 1};
    tbl[9]  = '{0, 0, 1, 2, 0};
    tbl[10] = '{0, 1, 1, 3, 1};
    tbl[11] = '{0, 0, 0, 3, 0};
    tbl[12] = '{0, 1, 0, 2, 1};
    tbl[13] = '{0, 1, 1, 2, 0};
    tbl[14] = '{0, 0, 0, 2, 0};
    tbl[15] = '{0, 0, 1, 2, 0};
    tbl[16] = '{1, 1, 1, 0, 0};
    tbl[17] = '{0, 1, 1, 0, 0};

    for (int i = 0; i < 18; i++) begin
      tick(tbl[i].r, tbl[i].s, tbl[i].d);
      chk($sformatf("tbl%0d_pos", i), pos, tbl[i].ep);
      chk($sformatf("tbl%0d_step", i), step, tbl[i].es);
      chk($sformatf("tbl%0d_leds", i), leds, longint'(1) << tbl[i].ep);
    end

    // up walk across the top end
`ifdef UPDOWN_STEPPER_BOUNCE_EN
    exp_up = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4};
`else
    exp_up = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2};
`endif
    do_reset();
    nsteps = 0;
    for (int i = 0; i < 10; i++) begin
      tick(0, 0, 1);
      nsteps += step;
      tick(0, 1, 1);
      nsteps += step;
      chk($sformatf("walk%0d_pos", i), pos, exp_up[i]);
    end
    chk("walk_steps", nsteps, 10);
`ifdef UPDOWN_STEPPER_BOUNCE_EN
    chk("bounce_heading", heading, 0);
    tick(1, 1, 1);
    chk("bounce_rst_pos", pos, 0);
    chk("bounce_rst_heading", heading, 1);
`endif

    // down from reset crosses the bottom end
    do_reset();
    pulse(0);
`ifdef UPDOWN_STEPPER_BOUNCE_EN
    chk("down_end_pos", pos, 1);
`else
    chk("down_wrap_pos", pos, 7);
    chk("down_wrap_leds", leds, 8'h80);
`endif

    // held tick yields exactly one step
    tick(0, 0, 1);
    nsteps = 0;
    for (int i = 0; i < 20; i++) begin
      tick(0, 1, 1);
      nsteps += step;
    end
    chk("held_steps", nsteps, 1);

    // random run against the model
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(0, 99) == 0),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0) ? dir : ~dir);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
